// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if - request/response bundle between the core and muldiv_unit.
//   master (core side) : drives start, funct3, op_a, op_b; observes busy, done, result, err
//   slave  (unit side) : the reverse
//   start   request, only looked at while the unit is idle
//   funct3  RV32M operation select
//   op_a    rs1 operand
//   op_b    rs2 operand
//   busy    an operation is in flight (core stalls)
//   done    one-cycle completion pulse
//   result  result word, held until the next completion
//   err     raised with done when the operation is not built in
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (
    output start, funct3, op_a, op_b,
    input  busy, done, result, err
  );

  modport slave (
    input  start, funct3, op_a, op_b,
    output busy, done, result, err
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit - iterative RV32M multiply/divide unit.
//   Multiply: shift-add on operand magnitudes, one bit per cycle, 2*WIDTH product.
//   Divide:   restoring division, one quotient bit per cycle, WIDTH+1 bit remainder.
//   Sign correction and high/low word selection happen in a final FIX cycle.
//   Division by zero and signed overflow bypass the iteration (fast path).
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; aborts any operation in flight
//   bus    muldiv_unit_if slave modport (start/funct3/op_a/op_b in,
//          busy/done/result/err out)
// Configuration:
//   MULDIV_DIV_EN  defined   : all eight funct3 operations, err tied low
//                  undefined : divider removed; funct3[2]=1 completes one
//                              cycle later with done=1, err=1, result=0
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;

  logic [2:0]         r_funct3;
  // r_a holds |op_a|; for divides it is also the dividend/quotient shift register.
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  // Product accumulator; for divides the low WIDTH+1 bits hold the partial remainder.
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_neg;
  logic               r_fast;
  logic [WIDTH-1:0]   r_fast_res;

  logic [WIDTH-1:0]   r_result;
  logic               r_done;

  // ---------------------------------------------------------------------------
  // Operand decode in IDLE
  // ---------------------------------------------------------------------------
  logic               w_a_signed;
  logic               w_b_signed;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_neg;
  logic               w_fast;
  logic [WIDTH-1:0]   w_fast_res;

  always_comb begin
    // MUL/MULH/MULHSU/DIV/REM treat rs1 as signed; MUL/MULH/DIV/REM also rs2.
    w_a_signed = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
    w_b_signed = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
    w_sa       = w_a_signed & bus.op_a[WIDTH-1];
    w_sb       = w_b_signed & bus.op_b[WIDTH-1];
    w_abs_a    = w_sa ? (-bus.op_a) : bus.op_a;
    w_abs_b    = w_sb ? (-bus.op_b) : bus.op_b;
    // Remainder follows the dividend; product and quotient follow the sign XOR.
    w_neg      = (bus.funct3[2] & bus.funct3[1]) ? w_sa : (w_sa ^ w_sb);
  end

`ifdef MULDIV_DIV_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic w_b_zero;
  logic w_ovf;

  always_comb begin
    w_b_zero   = (bus.op_b == '0);
    w_ovf      = bus.funct3[2] & ~bus.funct3[0] & (bus.op_a == MOST_NEG) & (bus.op_b == '1);
    w_fast     = bus.funct3[2] & (w_b_zero | w_ovf);
    w_fast_res = '0;
    if (w_b_zero)
      w_fast_res = bus.funct3[1] ? bus.op_a : '1;
    else if (w_ovf)
      w_fast_res = bus.funct3[1] ? '0 : bus.op_a;
  end
`else
  always_comb begin
    w_fast     = bus.funct3[2];
    w_fast_res = '0;
  end
`endif

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Fast-path operations also pass through FIX (with r_fast set) so they
  // complete one edge after acceptance, but they never raise busy.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = w_fast ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == CW'(WIDTH - 1))
          w_state_nxt = S_FIX;
      end
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_acc;

  always_comb begin
    w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_b[0] ? {1'b0, r_a} : '0);
    // Carry-out joins the shift so the accumulator never overflows.
    w_mul_acc = {w_sum, r_acc[WIDTH-1:1]};
  end

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_fits;
  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  always_comb begin
    w_shift   = {r_acc[WIDTH-1:0], r_a[WIDTH-1]};
    w_diff    = {1'b0, w_shift} - {2'b00, r_b};
    w_fits    = ~w_diff[WIDTH+1];
    w_rem_nxt = w_fits ? w_diff[WIDTH:0] : w_shift;
    w_quo_nxt = {r_a[WIDTH-2:0], w_fits};
  end
`endif

  // ---------------------------------------------------------------------------
  // Sign correction and word selection
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_mul_res;
  logic [WIDTH-1:0]   w_fix_res;

`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_div_res;
`endif

  always_comb begin
    w_prod    = r_neg ? (-r_acc) : r_acc;
    w_mul_res = (r_funct3[1:0] == 2'b00) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
    w_quo     = r_neg ? (-r_a) : r_a;
    w_rem     = r_neg ? (-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
    w_div_res = r_funct3[1] ? w_rem : w_quo;
    w_fix_res = r_fast ? r_fast_res : (r_funct3[2] ? w_div_res : w_mul_res);
`else
    w_fix_res = r_fast ? r_fast_res : w_mul_res;
`endif
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_funct3   <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_neg      <= 1'b0;
      r_fast     <= 1'b0;
      r_fast_res <= '0;
      r_result   <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_funct3   <= bus.funct3;
        r_a        <= w_abs_a;
        r_b        <= w_abs_b;
        r_acc      <= '0;
        r_cnt      <= '0;
        r_neg      <= w_neg;
        r_fast     <= w_fast;
        r_fast_res <= w_fast_res;
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt + CW'(1);
`ifdef MULDIV_DIV_EN
        if (r_funct3[2]) begin
          r_acc <= {{(WIDTH-1){1'b0}}, w_rem_nxt};
          r_a   <= w_quo_nxt;
        end else begin
          r_acc <= w_mul_acc;
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
        end
`else
        r_acc <= w_mul_acc;
        r_b   <= {1'b0, r_b[WIDTH-1:1]};
`endif
      end else if (r_state == S_FIX) begin
        r_result <= w_fix_res;
        r_done   <= 1'b1;
      end
    end
  end

`ifdef MULDIV_DIV_EN
  assign bus.err = 1'b0;
`else
  logic r_err;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_err <= 1'b0;
    else if (r_state == S_FIX)
      r_err <= r_funct3[2];
  end

  assign bus.err = r_err;
`endif

  assign bus.busy   = (r_state == S_CALC) || ((r_state == S_FIX) && !r_fast);
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit - directed self-checking bench for muldiv_unit (WIDTH=32).
// Expectations are hand-computed; divide vectors are selected by MULDIV_DIV_EN.
module tb_muldiv_unit;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) u_if ();

  muldiv_unit #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one operation right after a clock edge and follow it to done.
  // inj_at >= 0 drives a conflicting start (with new operands) that many
  // cycles into the operation.
  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_err,
                        input int exp_lat, input int exp_busy, input int inj_at);
    int n;
    int busy_cnt;
    bit seen;
    u_if.start  = 1'b1;
    u_if.funct3 = f3;
    u_if.op_a   = a;
    u_if.op_b   = b;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    n = 0;
    busy_cnt = 0;
    seen = 1'b0;
    while (!seen && n < 80) begin
      if (u_if.done) begin
        seen = 1'b1;
      end else begin
        busy_cnt += int'(u_if.busy);
        if (n == inj_at) begin
          u_if.start  = 1'b1;
          u_if.funct3 = 3'b011;
          u_if.op_a   = 32'd100;
          u_if.op_b   = 32'd100;
        end else begin
          u_if.start = 1'b0;
        end
        @(posedge clk); #1;
        n++;
      end
    end
    u_if.start = 1'b0;
    check({tag, " latency"}, n, exp_lat);
    check({tag, " result"}, u_if.result, exp_res);
    check({tag, " err"}, 32'(u_if.err), 32'(exp_err));
    check({tag, " busy in done cycle"}, 32'(u_if.busy), 32'd0);
    check({tag, " busy cycles"}, busy_cnt, exp_busy);
    @(posedge clk); #1;
    check({tag, " done one cycle"}, 32'(u_if.done), 32'd0);
    check({tag, " result held"}, u_if.result, exp_res);
  endtask

  initial begin
    int done_seen;
    rst_n       = 1'b0;
    u_if.start  = 1'b0;
    u_if.funct3 = 3'b000;
    u_if.op_a   = '0;
    u_if.op_b   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(u_if.busy), 32'd0);
    check("reset done", 32'(u_if.done), 32'd0);
    check("reset err", 32'(u_if.err), 32'd0);
    check("reset result", u_if.result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Multiply group
    run_op("MUL 7*-3",        3'b000, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33, 33, -1);
    run_op("MULHU -1*-1",     3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33, 33, -1);
    run_op("MULH -1*-1",      3'b001, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000, 1'b0, 33, 33, -1);
    run_op("MULHSU -1*max",   3'b010, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33, 33, -1);
    run_op("MULH min*min",    3'b001, 32'h80000000,  32'h80000000, 32'h40000000, 1'b0, 33, 33, -1);
    run_op("MULHSU min*max",  3'b010, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b0, 33, 33, -1);
    run_op("MUL 9*3",         3'b000, 32'd9,         32'd3,        32'd27,       1'b0, 33, 33, -1);

    // Reset at CALC cycle 10 aborts without a done pulse
    u_if.start  = 1'b1;
    u_if.funct3 = 3'b000;
    u_if.op_a   = 32'd123;
    u_if.op_b   = 32'd456;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort busy", 32'(u_if.busy), 32'd0);
    check("abort done", 32'(u_if.done), 32'd0);
    check("abort result", u_if.result, 32'd0);
    check("abort err", 32'(u_if.err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      done_seen += int'(u_if.done);
    end
    check("abort no done", done_seen, 32'd0);

    run_op("MUL after reset",   3'b000, 32'd6, 32'd7, 32'd42, 1'b0, 33, 33, -1);
    run_op("MUL start ignored", 3'b000, 32'd5, 32'd5, 32'd25, 1'b0, 33, 33, 5);

`ifdef MULDIV_DIV_EN
    run_op("DIV -20/3",       3'b100, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, 1'b0, 33, 33, -1);
    run_op("REM -20/3",       3'b110, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 1'b0, 33, 33, -1);
    run_op("REMU 20/3",       3'b111, 32'd20,       32'd3,        32'd2,        1'b0, 33, 33, -1);
    run_op("DIVU 20/3",       3'b101, 32'd20,       32'd3,        32'd6,        1'b0, 33, 33, -1);
    run_op("DIV 7/-2",        3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33, 33, -1);
    run_op("REM 7/-2",        3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        1'b0, 33, 33, -1);
    run_op("DIVU max/1",      3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0, 33, 33, -1);
    run_op("DIV x/0",         3'b100, 32'd1234,     32'd0,        32'hFFFFFFFF, 1'b0, 1,  0,  -1);
    run_op("REM 5/0",         3'b110, 32'd5,        32'd0,        32'd5,        1'b0, 1,  0,  -1);
    run_op("DIV ovf",         3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1,  0,  -1);
    run_op("REM ovf",         3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, 1,  0,  -1);
`else
    run_op("DIVU off",        3'b101, 32'd9,        32'd3,        32'd0,        1'b1, 1,  0,  -1);
    run_op("REM off",         3'b110, 32'd5,        32'd0,        32'd0,        1'b1, 1,  0,  -1);
    run_op("MUL after off",   3'b000, 32'd9,        32'd3,        32'd27,       1'b0, 33, 33, -1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
